// File: rtl/psum_ctrl_pkg.sv
// Shared types and lane arithmetic for the partial-sum accumulation controller.
package psum_ctrl_pkg;

   localparam int PSUM_BW = 16;
   localparam logic [PSUM_BW-1:0] LANE_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
   localparam logic [PSUM_BW-1:0] LANE_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, WAIT, RD, ACC, WR, DONE} psum_state_t;

   // Overflow shows up as disagreement between the sign-extended carry and the result MSB.
   function automatic logic [PSUM_BW-1:0] sat_add(input logic [PSUM_BW-1:0] a,
                                                  input logic [PSUM_BW-1:0] b);
      logic [PSUM_BW:0] s;
      s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
      if (s[PSUM_BW] != s[PSUM_BW-1]) return s[PSUM_BW] ? LANE_MIN : LANE_MAX;
      return s[PSUM_BW-1:0];
   endfunction

   function automatic logic [PSUM_BW-1:0] relu(input logic [PSUM_BW-1:0] a);
      return a[PSUM_BW-1] ? '0 : a;
   endfunction

endpackage

// File: rtl/psum_lane_add.sv
// Lane-parallel signed saturating adder with an optional per-lane ReLU clamp.
module psum_lane_add
   import psum_ctrl_pkg::*;
#(
   parameter int col     = 8,
   parameter int psum_bw = PSUM_BW
) (
   input  logic [col*psum_bw-1:0] a,
   input  logic [col*psum_bw-1:0] b,
   input  logic                   relu_en,
   output logic [col*psum_bw-1:0] y
);

   for (genvar l = 0; l < col; l++) begin : g_lane
      logic [psum_bw-1:0] s;
      assign s = sat_add(a[l*psum_bw +: psum_bw], b[l*psum_bw +: psum_bw]);
      assign y[l*psum_bw +: psum_bw] = relu_en ? relu(s) : s;
   end

endmodule

// File: rtl/psum_accum_ctrl.sv
// OFIFO -> PMEM read-modify-write partial-sum accumulator across all kij of one conv.
// Define PSUM_ACC_RELU_EN to clamp negative lanes to 0 on the final kij write.
module psum_accum_ctrl
   import psum_ctrl_pkg::*;
#(
   parameter int col     = 8,
   parameter int psum_bw = PSUM_BW,
   parameter int NUM_KIJ = 9,
   parameter int NUM_OUT = 16,
   parameter int AW      = 9
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [AW-1:0]          base_addr,
   input  logic                   ofifo_valid,
   input  logic [col*psum_bw-1:0] ofifo_out,
   output logic                   ofifo_rd,
   input  logic [col*psum_bw-1:0] pmem_q,
   output logic                   pmem_cen,
   output logic                   pmem_wen,
   output logic [AW-1:0]          pmem_addr,
   output logic [col*psum_bw-1:0] pmem_d,
   output logic                   busy,
   output logic                   done
);

   localparam int W  = col * psum_bw;
   localparam int OW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
   localparam int KW = (NUM_KIJ > 1) ? $clog2(NUM_KIJ) : 1;

   psum_state_t   state;
   logic [AW-1:0] base_r;
   logic [OW-1:0] out_idx;
   logic [KW-1:0] kij_idx;
   logic [W-1:0]  hold;
   logic [W-1:0]  add_out;
   logic          last_kij, last_out, relu_en;

   assign last_kij = (kij_idx == KW'(NUM_KIJ - 1));
   assign last_out = (out_idx == OW'(NUM_OUT - 1));

`ifdef PSUM_ACC_RELU_EN
   assign relu_en = last_kij;
`else
   assign relu_en = 1'b0;
`endif

   psum_lane_add #(.col(col), .psum_bw(psum_bw)) u_add (
      .a       (hold),
      .b       (pmem_q),
      .relu_en (relu_en),
      .y       (add_out)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         base_r    <= '0;
         out_idx   <= '0;
         kij_idx   <= '0;
         hold      <= '0;
         ofifo_rd  <= 1'b0;
         pmem_cen  <= 1'b1;
         pmem_wen  <= 1'b1;
         pmem_addr <= '0;
         pmem_d    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         ofifo_rd <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: if (start) begin
               base_r  <= base_addr;
               out_idx <= '0;
               kij_idx <= '0;
               busy    <= 1'b1;
               state   <= WAIT;
            end
            // Outputs are registered, so the next state's PMEM command is issued here.
            WAIT: if (ofifo_valid) begin
               ofifo_rd  <= 1'b1;
               hold      <= ofifo_out;
               pmem_cen  <= 1'b0;
               pmem_addr <= base_r + AW'(out_idx);
               if (kij_idx == '0) begin
                  pmem_wen <= 1'b0;
                  pmem_d   <= ofifo_out;
                  state    <= WR;
               end else begin
                  pmem_wen <= 1'b1;
                  state    <= RD;
               end
            end
            RD: begin
               pmem_cen <= 1'b1;
               state    <= ACC;
            end
            ACC: begin
               pmem_d   <= add_out;
               pmem_cen <= 1'b0;
               pmem_wen <= 1'b0;
               state    <= WR;
            end
            WR: begin
               pmem_cen <= 1'b1;
               pmem_wen <= 1'b1;
               if (last_out) begin
                  out_idx <= '0;
                  kij_idx <= kij_idx + KW'(1);
               end else begin
                  out_idx <= out_idx + OW'(1);
               end
               if (last_kij && last_out) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  state <= WAIT;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Scoreboard bench: reference model predicts every PMEM write; a monitor compares them.
module tb_psum_accum_ctrl;

   localparam int COL = 8, BW = 16, NK = 9, NO = 16, AW = 9;
   localparam int W = COL * BW, CW = AW + W;
`ifdef PSUM_ACC_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic          ofifo_valid = 1'b0;
   logic [W-1:0]  ofifo_out = '0;
   logic          ofifo_rd, pmem_cen, pmem_wen, busy, done;
   logic [W-1:0]  pmem_q, pmem_d;
   logic [AW-1:0] pmem_addr;

   psum_accum_ctrl #(.col(COL), .psum_bw(BW), .NUM_KIJ(NK), .NUM_OUT(NO), .AW(AW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd),
      .pmem_q(pmem_q), .pmem_cen(pmem_cen), .pmem_wen(pmem_wen),
      .pmem_addr(pmem_addr), .pmem_d(pmem_d), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int vecs = 0, errs = 0;
   int pops = 0, done_cnt = 0, gap = 0;
   int p0 = 0, d0 = 0;
   bit bp_en = 1'b0, flush = 1'b0;
   logic [W-1:0]  src[$], fifo[$];
   logic [CW-1:0] exp_q[$];
   logic [W-1:0]  mem [0:511];

   task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Behavioural SRAM: read data appears the cycle after a read command.
   always @(posedge clk)
      if (!pmem_cen) begin
         if (!pmem_wen) mem[pmem_addr] <= pmem_d;
         else           pmem_q <= mem[pmem_addr];
      end

   // Show-ahead OFIFO fed from src with optional random idle gaps.
   always @(negedge clk) begin
      if (flush) begin
         src.delete(); fifo.delete(); gap = 0;
      end else begin
         if (reset_n && ofifo_rd) begin
            chk("pop_while_valid", CW'(ofifo_valid), CW'(1));
            if (fifo.size() > 0) begin void'(fifo.pop_front()); pops++; end
         end
         if (gap > 0) gap--;
         else if (src.size() > 0) begin
            fifo.push_back(src.pop_front());
            gap = bp_en ? $urandom_range(0, 20) : 0;
         end
      end
      ofifo_valid = (fifo.size() > 0);
      ofifo_out   = ofifo_valid ? fifo[0] : '0;
   end

   // Monitor: every PMEM write is checked against the predicted write stream.
   always @(negedge clk) begin
      if (flush) exp_q.delete();
      else if (reset_n) begin
         if (!pmem_cen && !pmem_wen) begin
            if (exp_q.size() == 0) begin
               vecs++; errs++;
               $display("FAIL pmem_wr_extra: got %h expected no write", {pmem_addr, pmem_d});
            end else chk("pmem_wr", {pmem_addr, pmem_d}, exp_q.pop_front());
         end
         if (done) begin
            done_cnt++;
            chk("done_busy_empty", CW'({busy, exp_q.size() == 0}), CW'(2'b11));
         end
      end
   end

   function automatic logic [BW-1:0] sat(input int s);
      if (s > 32767)  return 16'h7FFF;
      if (s < -32768) return 16'h8000;
      return BW'(s);
   endfunction

   // mode 0: all +1; 1: random; 2: saturation lanes; 3: ReLU lanes
   task automatic start_conv(input logic [AW-1:0] base, input int mode, input bit bp);
      logic [W-1:0] acc [NO];
      logic [W-1:0] w;
      logic [BW-1:0] v;
      for (int k = 0; k < NK; k++)
         for (int n = 0; n < NO; n++) begin
            for (int l = 0; l < COL; l++) begin
               if (mode == 0) v = 16'd1;
               else if ($urandom_range(0, 1) == 1) v = BW'($urandom);
               else v = BW'(int'($urandom_range(0, 200)) - 100);
               if (mode == 2 && l == 0 && n == 0) v = (k == 0) ? 16'h7FF0 : 16'h0020;
               if (mode == 2 && l == 0 && n == 1) v = 16'h8000;
               if (mode == 3 && l == 3 && n == 0) v = (k == 0) ? 16'hFFFB : 16'h0000;
               if (mode == 3 && l == 3 && n == 1) v = (k == NK-1) ? 16'hFFF6 : 16'h0002;
               w[l*BW +: BW] = v;
            end
            src.push_back(w);
            for (int l = 0; l < COL; l++) begin
               if (k == 0) v = w[l*BW +: BW];
               else v = sat(int'($signed(acc[n][l*BW +: BW])) + int'($signed(w[l*BW +: BW])));
               if (RELU && k == NK-1 && v[BW-1]) v = '0;
               acc[n][l*BW +: BW] = v;
            end
            exp_q.push_back({AW'(base + AW'(n)), acc[n]});
         end
      p0 = pops; d0 = done_cnt;
      bp_en = bp; base_addr = base; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic finish_conv();
      int t = 0;
      while (done_cnt == d0 && t < 20000) begin @(negedge clk); t++; end
      repeat (3) @(negedge clk);
      chk("done_count", CW'(done_cnt - d0), CW'(1));
      chk("pop_count", CW'(pops - p0), CW'(144));
      chk("busy_after", CW'(busy), CW'(0));
      chk("sb_empty", CW'(exp_q.size()), CW'(0));
   endtask

   task automatic chk_reset_outs();
      chk("reset_ctl", CW'({ofifo_rd, pmem_cen, pmem_wen, pmem_addr, busy, done}),
          CW'({1'b0, 1'b1, 1'b1, 9'd0, 1'b0, 1'b0}));
      chk("reset_d", CW'(pmem_d), CW'(0));
   endtask

   initial begin
      #12;
      chk_reset_outs();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      start_conv(9'd0, 0, 1'b0);
      finish_conv();
      chk("t1_pix0", CW'(mem[0]), CW'({8{16'd9}}));
      chk("t1_pix15", CW'(mem[15]), CW'({8{16'd9}}));

      start_conv(9'd0, 2, 1'b0);
      finish_conv();
      chk("t2_pos_sat", CW'(mem[0][15:0]), CW'(16'h7FFF));
      chk("t2_neg_sat", CW'(mem[1][15:0]), CW'(16'h8000));

      start_conv(9'd0, 0, 1'b1);
      finish_conv();
      chk("t3_pix7", CW'(mem[7]), CW'({8{16'd9}}));
      start_conv(9'd37, 1, 1'b1);
      finish_conv();

      start_conv(9'd0, 3, 1'b1);
      finish_conv();
      chk("t4_relu_lane3", CW'(mem[0][63:48]), CW'(RELU ? 16'h0000 : 16'hFFFB));
      chk("t4_pos_lane3", CW'(mem[1][63:48]), CW'(16'h0006));

      start_conv(9'd510, 1, 1'b0);
      repeat (40) @(negedge clk);
      chk("t5_busy_mid", CW'(busy), CW'(1));
      base_addr = 9'd100; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      finish_conv();

      start_conv(9'd200, 1, 1'b1);
      begin
         int t = 0;
         while (pops - p0 < 4*NO + 3 && t < 20000) begin @(negedge clk); t++; end
         chk("t6_reach_kij4", CW'(t < 20000), CW'(1));
      end
      #2 reset_n = 1'b0;
      #1 chk_reset_outs();
      flush = 1'b1;
      repeat (2) @(negedge clk);
      flush = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      start_conv(9'd5, 1, 1'b1);
      finish_conv();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
